// File: rtl/simon_pkg.sv
// Simon 32/64 key-schedule constants and the round-key array type shared with the decryption pipeline.
// Pure declarations; no logic, no latency, no flow control.
package simon_pkg;

    localparam int NR   = 32;
    localparam int M    = 4;
    localparam int WORD = 16;

    // LSB-first: bit 0 is the first z0 term.
    localparam logic [61:0] Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;

    localparam logic [WORD-1:0] C_CONST = 16'hFFFC;

    typedef logic [NR-1:0][WORD-1:0] round_key_arr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } state_e;

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD - n));
    endfunction

endpackage

// File: rtl/simon_key_round.sv
// One Simon 32/64 key-schedule step: k_i from k_{i-4}, k_{i-3}, k_{i-1} and one z0 bit.
// Purely combinational, zero latency, no flow control.
module simon_key_round
    import simon_pkg::*;
(
    input  logic [WORD-1:0] k_im4_i,
    input  logic [WORD-1:0] k_im3_i,
    input  logic [WORD-1:0] k_im1_i,
    input  logic            z_bit_i,
    output logic [WORD-1:0] k_i_o
);

    logic [WORD-1:0] t0;
    logic [WORD-1:0] t1;

    assign t0    = ror(k_im1_i, 3) ^ k_im3_i;
    assign t1    = t0 ^ ror(t0, 1);
    assign k_i_o = C_CONST ^ k_im4_i ^ {{(WORD-1){1'b0}}, z_bit_i} ^ t1;

endmodule

// File: rtl/simon_key_expand.sv
// Iterative Simon 32/64 key expansion, one round key per cycle; key_valid 28 cycles after key_load.
// No backpressure: key_load is accepted in any state and restarts expansion immediately.
module simon_key_expand
    import simon_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           key_load,
    input  logic [63:0]    keytext,
    output logic           busy,
    output logic           key_valid,
    output round_key_arr_t key
);

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    round_key_arr_t  key_q, key_d;
    logic [WORD-1:0] k_new;

    simon_key_round u_round (
        .k_im4_i (key_q[cnt_q - 5'd4]),
        .k_im3_i (key_q[cnt_q - 5'd3]),
        .k_im1_i (key_q[cnt_q - 5'd1]),
        .z_bit_i (Z0[cnt_q - 5'd4]),
        .k_i_o   (k_new)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        // A load wins over an in-flight expansion; key[4..31] are simply overwritten later.
        if (key_load) begin
            for (int w = 0; w < M; w++) begin
                key_d[w] = keytext[w*WORD +: WORD];
            end
            cnt_d   = 5'(M);
            state_d = ST_EXPAND;
        end else if (state_q == ST_EXPAND) begin
            key_d[cnt_q] = k_new;
            cnt_d        = cnt_q + 5'd1;
            if (cnt_q == 5'(NR - 1)) begin
                state_d = ST_DONE;
            end
        end
    end

    assign busy      = (state_q == ST_EXPAND);
    assign key_valid = (state_q == ST_DONE);
    assign key       = key_q;

endmodule
